reg_bank_wb: RTL and testbench
==============================

Name: reg_bank_wb

Overview:
- Architectural register file for the multicycle CPU: 32 × 32-bit general-purpose registers.
- Receiver end of the write-register select path: consumes the 5-bit destination register number produced by the write-register mux, plus write data and write enable from the control unit.
- Provides two independent read ports for the rs/rt fields of the instruction register.
- Sits between the instruction register / write-back data mux and the A/B operand registers.

Parameters:
- DATA_W, 32, width of each register and of all data ports
- ADDR_W, 5, register-number width (2**ADDR_W registers)
- SP_IDX, 29, index of the stack-pointer register
- SP_RESET, 227, value loaded into register SP_IDX on reset

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- RegWrite  in  1  write enable from control unit
- WriteReg  in  ADDR_W  destination register number (write-register mux output)
- WriteData  in  DATA_W  value to store
- ReadReg1  in  ADDR_W  read port 1 register number (instr[25:21])
- ReadReg2  in  ADDR_W  read port 2 register number (instr[20:16])
- ReadData1  out  DATA_W  contents of ReadReg1
- ReadData2  out  DATA_W  contents of ReadReg2

Behaviour:
- Reset (synchronous, active-high):
  - On a rising clk edge with reset=1, every register clears to 0 except register SP_IDX, which loads SP_RESET.
  - Reset has priority over RegWrite in the same cycle; the write is discarded.
  - ReadData1/ReadData2 reflect the reset contents combinationally after that edge: 0, or SP_RESET when SP_IDX is addressed.
- Write path:
  - On a rising clk edge with reset=0 and RegWrite=1, the register at WriteReg takes WriteData.
  - Exactly one register changes per edge; all others hold.
  - RegWrite=0 means no register changes.
- Register 0:
  - Hardwired to 0.
  - Writes to WriteReg=0 are ignored silently; no error flag.
  - Reads of register 0 always return 0.
- Read path:
  - Asynchronous/combinational: ReadDataN = reg[ReadRegN] with zero clock latency.
  - Both ports may address the same register, or the register currently being written.
  - No write-through bypass: a read of WriteReg in the same cycle as the write returns the old value until the rising edge; the new value is visible immediately after the edge.
  - The multicycle control relies on this (A/B are latched a cycle after decode).
- Register SP_IDX and register 31 are ordinary registers after reset: fully writable, no special protection.
- Widths: WriteData is stored unmodified; no sign or zero extension inside the block.
- All WriteReg values 0–31 are legal; there are no out-of-range cases for ADDR_W=5.
- No X propagation: after the first reset edge, no output may be X for any defined address.
- Reset mid-operation: asserting reset during any multicycle instruction restores the reset image on the next edge regardless of the RegWrite/WriteReg values at that edge.
- Synthesis: storage is flip-flops (reset of all entries is required); no RAM inference.

Test Plan:
- Reset image: hold reset=1 for 1 edge with RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF -> sweep ReadReg1 over 0..31: every value 0 except reg 29 = 227; reg 5 = 0.
- Basic write/read: reset, then write reg 8 = 0x12345678 and reg 31 = 0x00400010 on successive edges -> ReadReg1=8 gives 0x12345678, ReadReg2=31 gives 0x00400010; all other registers unchanged.
- Register 0 guard: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF -> ReadData1 with ReadReg1=0 stays 0x00000000 before and after the edge.
- No bypass timing: reg 10 holds 0x11; in one cycle set RegWrite=1, WriteReg=10, WriteData=0x22, ReadReg1=ReadReg2=10 -> both reads 0x11 before the edge and 0x22 after it.
- Write-enable low: RegWrite=0, WriteReg=29, WriteData=0 for 4 edges -> reg 29 remains 227.
- Reset mid-stream: write reg 29 = 0x1000, then on the next edge assert reset with RegWrite=1, WriteReg=29, WriteData=0x2000 -> reg 29 = 227 after that edge; deassert reset and write 0x2000 -> reg 29 = 0x2000 one edge later.

Source files
------------

// File: rtl/reg_bank_wb.sv
// ---------------------------------------------------------------------------
// reg_bank_wb
//
// Architectural register file for the multicycle CPU: 2**ADDR_W registers
// of DATA_W bits each. Two combinational read ports serve the rs/rt fields
// of the instruction register. One synchronous write port is fed by the
// write-register mux and the write-back data mux.
//
// Ports
//   clk        rising-edge system clock
//   reset      synchronous, active-high; loads the reset image
//   RegWrite   write enable from the control unit
//   WriteReg   destination register number
//   WriteData  value stored into WriteReg
//   ReadReg1   read port 1 register number (instr[25:21])
//   ReadReg2   read port 2 register number (instr[20:16])
//   ReadData1  contents of ReadReg1, combinational
//   ReadData2  contents of ReadReg2, combinational
//
// Reset image: every register is 0 except SP_IDX, which holds SP_RESET.
// Register 0 reads as 0 at all times, and writes to it are ignored.
// The read ports have no write-through bypass. A register written on an
// edge shows its new value only after that edge. The multicycle control
// latches A/B a cycle after decode and depends on this timing.
// ---------------------------------------------------------------------------
module reg_bank_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int NREGS = 2 ** ADDR_W;

    // Flip-flop storage. Every entry has a reset value, so this array
    // cannot be mapped onto a RAM macro.
    logic [DATA_W-1:0] regs [NREGS];

    // Reset has priority over a write on the same edge. Register 0 is
    // never loaded, so it keeps the 0 it received at reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (RegWrite && (WriteReg != '0)) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // The explicit zero on address 0 keeps register 0 hardwired to 0 on
    // the read side too. Synthesis can then prune entry 0 altogether.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadReg1 != '0) ReadData1 = regs[ReadReg1];
        if (ReadReg2 != '0) ReadData2 = regs[ReadReg2];
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_wb
//
// Directed testbench for reg_bank_wb. The bench keeps its own image of the
// register file in model[]. Each scenario task drives the DUT and compares
// the read ports inline against hand-computed values or against that image.
// Inputs change 1 ns after a rising edge, and the outputs are sampled
// before the next edge.
// ---------------------------------------------------------------------------
module tb_reg_bank_wb;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int SP_IDX   = 29;
    localparam int SP_RESET = 227;
    localparam int NREGS    = 32;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    always #5 clk = ~clk;

    reg_bank_wb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SP_IDX  (SP_IDX),
        .SP_RESET(SP_RESET)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RegWrite (RegWrite),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] model [NREGS];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_v;
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        model[SP_IDX] = DATA_W'(SP_RESET);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        RegWrite = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        RegWrite  = 1'b1;
        WriteReg  = a;
        WriteData = d;
        tick();
        RegWrite = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    // ---------------- scenarios ----------------
    // Reset is asserted together with a write to reg 5. The write must be
    // dropped, and the whole image is then swept on both ports.
    task automatic test_reset();
        reset     = 1'b1;
        RegWrite  = 1'b1;
        WriteReg  = 5'd5;
        WriteData = 32'hDEADBEEF;
        tick();
        reset    = 1'b0;
        RegWrite = 1'b0;
        model_reset();
        for (int i = 0; i < NREGS; i++) exp_q.push_back((i == SP_IDX) ? 32'd227 : 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            ReadReg1 = ADDR_W'(i);
            ReadReg2 = ADDR_W'(NREGS - 1 - i);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (ReadData1 !== exp_v) begin
                n_fail++;
                $display("FAIL reset_image_p1 reg %0d: got %h expected %h", i, ReadData1, exp_v);
            end
            n_checks++;
            if (ReadData2 !== model[NREGS - 1 - i]) begin
                n_fail++;
                $display("FAIL reset_image_p2 reg %0d: got %h expected %h",
                         NREGS - 1 - i, ReadData2, model[NREGS - 1 - i]);
            end
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        do_write(5'd8, 32'h12345678);
        do_write(5'd31, 32'h00400010);
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd31;
        #1;
        n_checks++;
        if (ReadData1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL basic_rd1_reg8: got %h expected %h", ReadData1, 32'h12345678);
        end
        n_checks++;
        if (ReadData2 !== 32'h00400010) begin
            n_fail++;
            $display("FAIL basic_rd2_reg31: got %h expected %h", ReadData2, 32'h00400010);
        end
        // The other registers must still hold the reset image.
        for (int i = 0; i < NREGS; i++) begin
            ReadReg1 = ADDR_W'(i);
            #1;
            exp_v = (i == 8) ? 32'h12345678 : (i == 31) ? 32'h00400010 :
                    (i == SP_IDX) ? 32'd227 : 32'd0;
            n_checks++;
            if (ReadData1 !== exp_v) begin
                n_fail++;
                $display("FAIL basic_sweep reg %0d: got %h expected %h", i, ReadData1, exp_v);
            end
        end
    endtask

    task automatic test_reg0();
        ReadReg1  = 5'd0;
        RegWrite  = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'hFFFFFFFF;
        #1;
        n_checks++;
        if (ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reg0_before_edge: got %h expected %h", ReadData1, 32'h0);
        end
        tick();
        RegWrite = 1'b0;
        n_checks++;
        if (ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reg0_after_edge: got %h expected %h", ReadData1, 32'h0);
        end
    endtask

    task automatic test_no_bypass();
        do_write(5'd10, 32'h11);
        ReadReg1  = 5'd10;
        ReadReg2  = 5'd10;
        RegWrite  = 1'b1;
        WriteReg  = 5'd10;
        WriteData = 32'h22;
        #1;
        n_checks++;
        if (ReadData1 !== 32'h11) begin
            n_fail++;
            $display("FAIL nobypass_rd1_before: got %h expected %h", ReadData1, 32'h11);
        end
        n_checks++;
        if (ReadData2 !== 32'h11) begin
            n_fail++;
            $display("FAIL nobypass_rd2_before: got %h expected %h", ReadData2, 32'h11);
        end
        tick();
        RegWrite  = 1'b0;
        model[10] = 32'h22;
        n_checks++;
        if (ReadData1 !== 32'h22) begin
            n_fail++;
            $display("FAIL nobypass_rd1_after: got %h expected %h", ReadData1, 32'h22);
        end
        n_checks++;
        if (ReadData2 !== 32'h22) begin
            n_fail++;
            $display("FAIL nobypass_rd2_after: got %h expected %h", ReadData2, 32'h22);
        end
    endtask

    task automatic test_we_low();
        RegWrite  = 1'b0;
        WriteReg  = 5'd29;
        WriteData = 32'h0;
        repeat (4) tick();
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd10;
        #1;
        n_checks++;
        if (ReadData1 !== 32'd227) begin
            n_fail++;
            $display("FAIL we_low_reg29: got %h expected %h", ReadData1, 32'd227);
        end
        n_checks++;
        if (ReadData2 !== 32'h22) begin
            n_fail++;
            $display("FAIL we_low_reg10: got %h expected %h", ReadData2, 32'h22);
        end
    endtask

    // Writes all registers on consecutive edges with distinct patterns,
    // including the MSB, and then sweeps both ports against the model.
    task automatic test_back_to_back();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < NREGS; i++) begin
            v = (32'h01010101 * 32'(i)) ^ 32'hA5000000 ^ ((i % 2 == 1) ? 32'h80000000 : 32'h0);
            do_write(ADDR_W'(i), v);
        end
        for (int i = 0; i < NREGS; i++) begin
            ReadReg1 = ADDR_W'(i);
            ReadReg2 = ADDR_W'((i + 7) % NREGS);
            #1;
            n_checks++;
            if (ReadData1 !== model[i]) begin
                n_fail++;
                $display("FAIL b2b_p1 reg %0d: got %h expected %h", i, ReadData1, model[i]);
            end
            n_checks++;
            if (ReadData2 !== model[(i + 7) % NREGS]) begin
                n_fail++;
                $display("FAIL b2b_p2 reg %0d: got %h expected %h",
                         (i + 7) % NREGS, ReadData2, model[(i + 7) % NREGS]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd8;
        do_write(5'd29, 32'h1000);
        n_checks++;
        if (ReadData1 !== 32'h1000) begin
            n_fail++;
            $display("FAIL mid_reg29_written: got %h expected %h", ReadData1, 32'h1000);
        end
        reset     = 1'b1;
        RegWrite  = 1'b1;
        WriteReg  = 5'd29;
        WriteData = 32'h2000;
        tick();
        reset    = 1'b0;
        RegWrite = 1'b0;
        model_reset();
        n_checks++;
        if (ReadData1 !== 32'd227) begin
            n_fail++;
            $display("FAIL mid_reg29_reset: got %h expected %h", ReadData1, 32'd227);
        end
        n_checks++;
        if (ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reg8_reset: got %h expected %h", ReadData2, 32'h0);
        end
        do_write(5'd29, 32'h2000);
        n_checks++;
        if (ReadData1 !== 32'h2000) begin
            n_fail++;
            $display("FAIL mid_reg29_rewrite: got %h expected %h", ReadData1, 32'h2000);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        model_reset();
        #2;
        test_reset();
        test_basic_write();
        test_reg0();
        test_no_bypass();
        test_we_low();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
